// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: shares one binary-to-BCD converter among N_REQ requesters.
// Requests are granted round-robin, operands above 9999 saturate without
// touching the converter, and a watchdog turns a hung conversion into an
// error response so the block can never lock up.
module bcd_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [14*N_REQ-1:0]   bin_in,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [15:0]           rsp_bcd,
    output logic                  rsp_ovf,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  cv_start,
    output logic [13:0]           cv_bin,
    input  logic                  cv_ready,
    input  logic                  cv_done_tick,
    input  logic [15:0]           cv_bcd
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   grant, grant_n;
    logic [GW-1:0]   last_grant, last_grant_n;
    logic [13:0]     op_reg, op_n;
    logic [7:0]      wdog, wdog_n;

    logic [N_REQ-1:0] rsp_valid_n;
    logic [15:0]      rsp_bcd_n;
    logic             rsp_ovf_n;
    logic             rsp_err_n;
    logic             busy_n;
    logic             cv_start_n;
    logic [13:0]      cv_bin_n;

    logic [GW-1:0]   cand;
    logic [GW-1:0]   pick;
    logic            found;
    logic [13:0]     op_sel;

    // Round-robin search: first requesting index starting just above last_grant
    always_comb begin
        cand  = '0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = GW'((int'(last_grant) + 1 + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        op_sel = bin_in[14*int'(pick) +: 14];
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        op_n         = op_reg;
        wdog_n       = wdog;
        rsp_valid_n  = '0;
        rsp_bcd_n    = rsp_bcd;
        rsp_ovf_n    = rsp_ovf;
        rsp_err_n    = rsp_err;
        cv_start_n   = 1'b0;
        cv_bin_n     = '0;

        case (state)
            IDLE: begin
                if (found && cv_ready) begin
                    grant_n = pick;
                    op_n    = op_sel;
                    state_n = START;
                    if (op_sel <= 14'd9999) begin
                        cv_start_n = 1'b1;
                        cv_bin_n   = op_sel;
                    end
                end
            end
            START: begin
                if (op_reg > 14'd9999) begin
                    rsp_bcd_n   = 16'h9999;
                    rsp_ovf_n   = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = N_REQ'(1) << grant;
                    state_n     = RESP;
                end else begin
                    wdog_n  = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                wdog_n = wdog + 8'd1;
                if (cv_done_tick) begin
                    rsp_bcd_n   = cv_bcd;
                    rsp_ovf_n   = 1'b0;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = N_REQ'(1) << grant;
                    state_n     = RESP;
                end else if (wdog == 8'(TIMEOUT - 1)) begin
                    rsp_bcd_n   = 16'h0000;
                    rsp_ovf_n   = 1'b0;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = N_REQ'(1) << grant;
                    state_n     = RESP;
                end
            end
            RESP: begin
                last_grant_n = grant;
                state_n      = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(N_REQ - 1);
            op_reg     <= '0;
            wdog       <= '0;
            rsp_valid  <= '0;
            rsp_bcd    <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            cv_start   <= 1'b0;
            cv_bin     <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            op_reg     <= op_n;
            wdog       <= wdog_n;
            rsp_valid  <= rsp_valid_n;
            rsp_bcd    <= rsp_bcd_n;
            rsp_ovf    <= rsp_ovf_n;
            rsp_err    <= rsp_err_n;
            busy       <= busy_n;
            cv_start   <= cv_start_n;
            cv_bin     <= cv_bin_n;
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed testbench for bcd_conv_arbiter with a behavioural bin2bcd stub.
module tb_bcd_conv_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [55:0] bin_in;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_bcd;
    logic        rsp_ovf;
    logic        rsp_err;
    logic        busy;
    logic        cv_start;
    logic [13:0] cv_bin;
    logic        cv_ready;
    logic        cv_done_tick;
    logic [15:0] cv_bcd;

    logic        stub_dead;
    logic        stub_active;
    int          stub_cnt;
    logic [13:0] stub_val;

    int errors;
    int checks;

    bcd_conv_arbiter #(.N_REQ(4), .TIMEOUT(31)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .bin_in       (bin_in),
        .rsp_valid    (rsp_valid),
        .rsp_bcd      (rsp_bcd),
        .rsp_ovf      (rsp_ovf),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .cv_start     (cv_start),
        .cv_bin       (cv_bin),
        .cv_ready     (cv_ready),
        .cv_done_tick (cv_done_tick),
        .cv_bcd       (cv_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input logic [13:0] b);
        int v;
        v = int'(b);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Converter stub: start seen at one edge, 14 shift cycles, then done_tick
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stub_active  <= 1'b0;
            stub_cnt     <= 0;
            stub_val     <= '0;
            cv_ready     <= 1'b1;
            cv_done_tick <= 1'b0;
            cv_bcd       <= '0;
        end else begin
            cv_done_tick <= 1'b0;
            if (!stub_active) begin
                if (cv_start && cv_ready && !stub_dead) begin
                    stub_active <= 1'b1;
                    stub_cnt    <= 0;
                    stub_val    <= cv_bin;
                    cv_ready    <= 1'b0;
                end
            end else if (stub_cnt == 13) begin
                cv_done_tick <= 1'b1;
                cv_bcd       <= to_bcd(stub_val);
                stub_active  <= 1'b0;
                cv_ready     <= 1'b1;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Step cycles after a request until a response appears or the budget runs out
    task automatic wait_rsp(input int budget, output int cyc, output int start_cyc,
                            output logic [13:0] start_bin, output logic [3:0] v,
                            output logic [15:0] bcd, output logic ovf, output logic err);
        cyc = -1; start_cyc = -1; start_bin = '0; v = '0; bcd = '0; ovf = 1'b0; err = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (cv_start && start_cyc < 0) begin
                start_cyc = k;
                start_bin = cv_bin;
            end
            if (rsp_valid != 4'b0000) begin
                cyc = k; v = rsp_valid; bcd = rsp_bcd; ovf = rsp_ovf; err = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_bcd, rsp_ovf, rsp_err, busy, cv_start, cv_bin} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {rsp_valid, rsp_bcd, rsp_ovf, rsp_err, busy, cv_start, cv_bin});
        end
        do_reset();
    endtask

    task automatic test_single();
        int cyc, sc; logic [13:0] sb; logic [3:0] v; logic [15:0] b; logic o, e;
        do_reset();
        bin_in[13:0] = 14'd1234;
        req = 4'b0001;
        wait_rsp(40, cyc, sc, sb, v, b, o, e);
        req = 4'b0000;
        checks++;
        if (sc !== 1 || sb !== 14'd1234) begin
            errors++; $display("[TB] FAIL single_start: got cyc %0d bin %0d expected cyc 1 bin 1234", sc, sb);
        end
        checks++;
        if (cyc !== 17 || v !== 4'b0001) begin
            errors++; $display("[TB] FAIL single_valid: got cyc %0d valid %b expected cyc 17 valid 0001", cyc, v);
        end
        checks++;
        if (b !== 16'h1234 || o !== 1'b0 || e !== 1'b0) begin
            errors++; $display("[TB] FAIL single_data: got %h ovf %b err %b expected 1234 0 0", b, o, e);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000 || rsp_bcd !== 16'h1234) begin
            errors++; $display("[TB] FAIL single_after: got busy %b valid %b bcd %h expected 0 0000 1234",
                               busy, rsp_valid, rsp_bcd);
        end
    endtask

    task automatic test_two_requesters();
        int cyc, sc; logic [13:0] sb; logic [3:0] v; logic [15:0] b; logic o, e;
        do_reset();
        bin_in[13:0]  = 14'd42;
        bin_in[41:28] = 14'd9999;
        req = 4'b0101;
        wait_rsp(40, cyc, sc, sb, v, b, o, e);
        req = 4'b0100;
        checks++;
        if (cyc !== 17 || v !== 4'b0001 || b !== 16'h0042) begin
            errors++; $display("[TB] FAIL two_first: got cyc %0d valid %b bcd %h expected 17 0001 0042", cyc, v, b);
        end
        wait_rsp(40, cyc, sc, sb, v, b, o, e);
        req = 4'b0000;
        checks++;
        if (cyc !== 18 || v !== 4'b0100 || b !== 16'h9999 || o !== 1'b0) begin
            errors++; $display("[TB] FAIL two_second: got cyc %0d valid %b bcd %h ovf %b expected 18 0100 9999 0",
                               cyc, v, b, o);
        end
    endtask

    task automatic test_all_four();
        int cyc, sc; logic [13:0] sb; logic [3:0] v; logic [15:0] b; logic o, e;
        logic [3:0]  exp_v [6];
        logic [15:0] exp_b [6];
        exp_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_b = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 16'h2222};
        do_reset();
        bin_in = {14'd4444, 14'd3333, 14'd2222, 14'd1111};
        req = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            wait_rsp(40, cyc, sc, sb, v, b, o, e);
            checks++;
            if (cyc !== ((n == 0) ? 17 : 18) || v !== exp_v[n] || b !== exp_b[n]) begin
                errors++;
                $display("[TB] FAIL rr_order_%0d: got cyc %0d valid %b bcd %h expected cyc %0d valid %b bcd %h",
                         n, cyc, v, b, (n == 0) ? 17 : 18, exp_v[n], exp_b[n]);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_overflow();
        int cyc, sc; logic [13:0] sb; logic [3:0] v; logic [15:0] b; logic o, e;
        logic [13:0] ops [3];
        ops = '{14'd12000, 14'd16383, 14'd10000};
        do_reset();
        for (int n = 0; n < 3; n++) begin
            bin_in[27:14] = ops[n];
            req = 4'b0010;
            wait_rsp(40, cyc, sc, sb, v, b, o, e);
            req = 4'b0000;
            checks++;
            if (sc !== -1 || cyc !== 2 || v !== 4'b0010 || b !== 16'h9999 || o !== 1'b1 || e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ovf_%0d: got start %0d cyc %0d valid %b bcd %h ovf %b err %b expected -1 2 0010 9999 1 0",
                         ops[n], sc, cyc, v, b, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int cyc, sc; logic [13:0] sb; logic [3:0] v; logic [15:0] b; logic o, e;
        do_reset();
        stub_dead = 1'b1;
        bin_in[13:0] = 14'd500;
        req = 4'b0001;
        wait_rsp(60, cyc, sc, sb, v, b, o, e);
        req = 4'b0000;
        stub_dead = 1'b0;
        checks++;
        if (cyc !== 33 || v !== 4'b0001 || b !== 16'h0000 || e !== 1'b1) begin
            errors++; $display("[TB] FAIL timeout_rsp: got cyc %0d valid %b bcd %h err %b expected 33 0001 0000 1",
                               cyc, v, b, e);
        end
        @(negedge clk);
        bin_in[13:0] = 14'd0;
        req = 4'b0001;
        wait_rsp(40, cyc, sc, sb, v, b, o, e);
        req = 4'b0000;
        checks++;
        if (cyc !== 17 || v !== 4'b0001 || b !== 16'h0000 || e !== 1'b0 || o !== 1'b0) begin
            errors++; $display("[TB] FAIL after_timeout: got cyc %0d valid %b bcd %h err %b ovf %b expected 17 0001 0000 0 0",
                               cyc, v, b, e, o);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, sc; logic [13:0] sb; logic [3:0] v; logic [15:0] b; logic o, e;
        int seen;
        do_reset();
        bin_in = {14'd8, 14'd7, 14'd6, 14'd5};
        req = 4'b0010;
        wait_rsp(40, cyc, sc, sb, v, b, o, e);
        req = 4'b0100;
        for (int k = 0; k < 8; k++) @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        checks++;
        if ({rsp_valid, rsp_bcd, rsp_ovf, rsp_err, busy, cv_start, cv_bin} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %h expected 0",
                     {rsp_valid, rsp_bcd, rsp_ovf, rsp_err, busy, cv_start, cv_bin});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid != 4'b0000) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("[TB] FAIL reset_mid_no_rsp: got %0d pulses expected 0", seen);
        end
        req = 4'b1001;
        wait_rsp(40, cyc, sc, sb, v, b, o, e);
        req = 4'b1000;
        checks++;
        if (cyc !== 17 || v !== 4'b0001 || b !== 16'h0005) begin
            errors++; $display("[TB] FAIL reset_mid_first: got cyc %0d valid %b bcd %h expected 17 0001 0005", cyc, v, b);
        end
        wait_rsp(40, cyc, sc, sb, v, b, o, e);
        req = 4'b0000;
        checks++;
        if (cyc !== 18 || v !== 4'b1000 || b !== 16'h0008) begin
            errors++; $display("[TB] FAIL reset_mid_second: got cyc %0d valid %b bcd %h expected 18 1000 0008", cyc, v, b);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        req       = '0;
        bin_in    = '0;
        stub_dead = 1'b0;
        test_reset();
        test_single();
        test_two_requesters();
        test_all_four();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
